// File: rtl/acc_lane_packer_if.sv
// Handshake bundle between the accumulator stream, the packer and
// the downstream 3-lane result FIFO.
`ifndef ACCW
`define ACCW 8
`endif

interface acc_lane_packer_if #(
  parameter int DW    = `ACCW,
  parameter int LANES = 3
);
  logic                  in_valid;
  logic [DW-1:0]         in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_wr_en;
  logic [LANES*DW-1:0]   out_wr_data;
  logic                  out_wr_ok;
  logic [LANES-1:0]      out_pad;
  logic [15:0]           words_sent;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_wr_ok,
    input  in_ready,
    input  out_wr_en,
    input  out_wr_data,
    input  out_pad,
    input  words_sent
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_wr_ok,
    output in_ready,
    output out_wr_en,
    output out_wr_data,
    output out_pad,
    output words_sent
  );
endinterface

// File: rtl/acc_lane_packer.sv
// Packs ACCW-wide accumulator results into 3-lane words for the
// result FIFO; short groups are zero padded and flushed on in_last.
`ifndef ACCW
`define ACCW 8
`endif

module acc_lane_packer #(
  parameter int DW    = `ACCW,
  parameter int LANES = 3,
  parameter int CW    = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  acc_lane_packer_if.slave  bus
);

  logic [DW-1:0]       asm_q [LANES];
  logic [CW-1:0]       lane_q;
  logic [LANES*DW-1:0] obuf_q;
  logic [LANES-1:0]    opad_q;
  logic                ovld_q;
  logic [15:0]         cnt_q;

  logic                xfer;
  logic                done;
  logic                wr;
  logic [LANES*DW-1:0] nxt_word;
  logic [LANES-1:0]    nxt_pad;

  assign bus.in_ready    = !ovld_q || bus.out_wr_ok;
  assign wr              = ovld_q && bus.out_wr_ok && !rst;
  assign bus.out_wr_en   = wr;
  assign bus.out_wr_data = obuf_q;
  assign bus.out_pad     = opad_q;
  assign bus.words_sent  = cnt_q;

  assign xfer = bus.in_valid && bus.in_ready;
  assign done = xfer &&
                (bus.in_last || lane_q == CW'(LANES-1));

  // Lanes below the current one come from the assembly
  // register; the incoming element bypasses it.
  always_comb begin
    nxt_word = '0;
    nxt_pad  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) < lane_q)
        nxt_word[k*DW +: DW] = asm_q[k];
      else if (CW'(k) == lane_q)
        nxt_word[k*DW +: DW] = bus.in_data;
      else
        nxt_pad[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++)
        asm_q[k] <= '0;
      lane_q <= '0;
      obuf_q <= '0;
      opad_q <= '0;
      ovld_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (xfer) begin
        asm_q[lane_q] <= bus.in_data;
        lane_q <= done ? '0 : lane_q + CW'(1);
      end
      // A completing word overwrites a draining one: no bubble.
      if (done) begin
        obuf_q <= nxt_word;
        opad_q <= nxt_pad;
        ovld_q <= 1'b1;
      end else if (wr) begin
        ovld_q <= 1'b0;
      end
      if (wr)
        cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_acc_lane_packer.sv
// Randomized scoreboard bench for acc_lane_packer against a
// queue-based group model.
module tb_acc_lane_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_lane_packer_if #(.DW(8), .LANES(3)) bus ();

  acc_lane_packer #(.DW(8), .LANES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  // 0: ok forced 1, 1: ok forced 0, 2: random
  int ok_mode = 0;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  pad;
  } word_t;

  word_t      exp_q [$];
  logic [7:0] grp [$];
  logic [15:0] exp_ws = 16'd0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    case (ok_mode)
      0: bus.out_wr_ok = 1'b1;
      1: bus.out_wr_ok = 1'b0;
      default: bus.out_wr_ok = ($urandom_range(0, 9) < 6);
    endcase
  end

  // Monitor: samples between edges, after the driver settles.
  always begin
    word_t w;
    word_t e;
    @(negedge clk);
    #2;
    if (rst) begin
      grp.delete();
      exp_q.delete();
      exp_ws = 16'd0;
      chk("wr_en_in_reset", {31'd0, bus.out_wr_en}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, bus.in_ready},
          {31'd0, exp_q.size() == 0 || bus.out_wr_ok});
      chk("wr_en", {31'd0, bus.out_wr_en},
          {31'd0, exp_q.size() != 0 && bus.out_wr_ok});
      chk("words_sent", {16'd0, bus.words_sent}, {16'd0, exp_ws});
      if (bus.out_wr_en) begin
        chk("wr_en_vs_ok", {31'd0, bus.out_wr_ok}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", {8'd0, bus.out_wr_data}, {8'd0, e.data});
          chk("out_pad", {29'd0, bus.out_pad}, {29'd0, e.pad});
        end
        exp_ws = exp_ws + 16'd1;
      end
      if (bus.in_valid && bus.in_ready) begin
        grp.push_back(bus.in_data);
        if (grp.size() == 3 || bus.in_last) begin
          w.data = '0;
          w.pad  = '0;
          for (int i = 0; i < 3; i++) begin
            if (i < grp.size()) w.data[i*8 +: 8] = grp[i];
            else w.pad[i] = 1'b1;
          end
          exp_q.push_back(w);
          grp.delete();
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    n = 0;
    #1;
    while (!bus.in_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 500) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, bus.out_wr_en}, 32'd0);
    chk("rst_words", {16'd0, bus.words_sent}, 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_wr_ok = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), 1'b0);
    idle(3);
    chk("ws_after_6", {16'd0, bus.words_sent}, 32'd2);

    send(8'hA1, 1'b0);
    send(8'hA2, 1'b1);
    send(8'hB1, 1'b1);
    idle(3);

    ok_mode = 1;
    fork
      for (int i = 0; i < 5; i++) send(8'hC1 + 8'(i), 1'b0);
      begin
        repeat (8) @(negedge clk);
        ok_mode = 0;
      end
    join
    send(8'hC6, 1'b1);
    idle(3);

    ok_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(8'($urandom), ($urandom_range(0, 9) == 0));
    end
    send(8'h5A, 1'b1);
    ok_mode = 0;
    idle(4);

    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    do_reset();
    ok_mode = 1;
    for (int i = 0; i < 3; i++) send(8'hE1 + 8'(i), 1'b0);
    idle(2);
    do_reset();
    ok_mode = 0;
    for (int i = 0; i < 3; i++) send(8'hF1 + 8'(i), 1'b0);
    idle(3);
    chk("ws_after_rst", {16'd0, bus.words_sent}, 32'd1);

    do_reset();
    for (int i = 0; i < 65536; i++) send(8'(i), 1'b1);
    idle(3);
    chk("ws_wrap", {16'd0, bus.words_sent}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
